// File: rtl/calendar_date_counter.sv
// calendar_date_counter: registered day/month/year calendar advancing one day per tick.
// Define GREGORIAN_EN for the full Gregorian leap rule; otherwise every 4th year is leap.
module calendar_date_counter #(
    parameter int YEAR_W     = 11,
    parameter int RESET_YEAR = 2000
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              tick_i,
    input  logic              load_i,
    input  logic [YEAR_W-1:0] load_year_i,
    input  logic [3:0]        load_month_i,
    input  logic [4:0]        load_day_i,
    output logic [YEAR_W-1:0] year_o,
    output logic [3:0]        month_o,
    output logic [4:0]        day_o,
    output logic [8:0]        doy_o,
    output logic              leap_o,
    output logic              year_wrap_o,
    output logic              load_err_o
);
    logic [YEAR_W-1:0] year_q, year_d;
    logic [3:0]        month_q, month_d;
    logic [4:0]        day_q, day_d;
    logic [8:0]        doy_q, doy_d;
    logic              year_wrap_q, year_wrap_d;
    logic              load_err_q, load_err_d;
    logic              load_ok;
    logic              load_leap;

    function automatic logic is_leap(input logic [YEAR_W-1:0] y);
`ifdef GREGORIAN_EN
        int yi;
        yi = int'(y);
        return ((yi % 4 == 0) && (yi % 100 != 0)) || (yi % 400 == 0);
`else
        return y[1:0] == 2'b00;
`endif
    endfunction

    function automatic logic [4:0] dim(input logic lp, input logic [3:0] m);
        return (m == 4'd2) ? (lp ? 5'd29 : 5'd28) :
               (m == 4'd4 || m == 4'd6 || m == 4'd9 || m == 4'd11) ? 5'd30 : 5'd31;
    endfunction

    // Days elapsed before the first of month m in a common year.
    function automatic logic [8:0] cum_days(input logic [3:0] m);
        case (m)
            4'd2:    return 9'd31;
            4'd3:    return 9'd59;
            4'd4:    return 9'd90;
            4'd5:    return 9'd120;
            4'd6:    return 9'd151;
            4'd7:    return 9'd181;
            4'd8:    return 9'd212;
            4'd9:    return 9'd243;
            4'd10:   return 9'd273;
            4'd11:   return 9'd304;
            4'd12:   return 9'd334;
            default: return 9'd0;
        endcase
    endfunction

    assign load_leap = is_leap(load_year_i);
    assign load_ok   = (load_month_i >= 4'd1) && (load_month_i <= 4'd12) && (load_day_i != 5'd0) &&
                       (load_day_i <= dim(load_leap, load_month_i));

    always_comb begin
        year_d      = year_q;
        month_d     = month_q;
        day_d       = day_q;
        doy_d       = doy_q;
        year_wrap_d = 1'b0;
        load_err_d  = 1'b0;
        if (load_i) begin
            if (load_ok) begin
                year_d  = load_year_i;
                month_d = load_month_i;
                day_d   = load_day_i;
                doy_d   = cum_days(load_month_i) + {4'd0, load_day_i} +
                          {8'd0, load_leap && (load_month_i > 4'd2)};
            end else begin
                load_err_d = 1'b1;
            end
        end else if (tick_i) begin
            if (day_q < dim(leap_o, month_q)) begin
                day_d = day_q + 5'd1;
                doy_d = doy_q + 9'd1;
            end else if (month_q < 4'd12) begin
                day_d   = 5'd1;
                month_d = month_q + 4'd1;
                doy_d   = doy_q + 9'd1;
            end else begin
                day_d       = 5'd1;
                month_d     = 4'd1;
                doy_d       = 9'd1;
                year_d      = year_q + 1'b1;
                year_wrap_d = &year_q;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            year_q      <= YEAR_W'(RESET_YEAR);
            month_q     <= 4'd1;
            day_q       <= 5'd1;
            doy_q       <= 9'd1;
            year_wrap_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            year_q      <= year_d;
            month_q     <= month_d;
            day_q       <= day_d;
            doy_q       <= doy_d;
            year_wrap_q <= year_wrap_d;
            load_err_q  <= load_err_d;
        end
    end

    assign year_o      = year_q;
    assign month_o     = month_q;
    assign day_o       = day_q;
    assign doy_o       = doy_q;
    assign leap_o      = is_leap(year_q);
    assign year_wrap_o = year_wrap_q;
    assign load_err_o  = load_err_q;
endmodule
